ppu_bg_fetch: RTL and testbench

//  Initiator side of the CHR bus: the PPU background tile fetch sequencer that drives chr_a/chr_r_nw into the cartridge.
//  Per tile it performs four reads (nametable, attribute, pattern low, pattern high) and presents the assembled tile to the pixel shifters.
//  It steps the loopy-v coarse X across a scanline.
//  It sits between the PPU timing generator (dot enables, line starts) and the cartridge CHR/CIRAM port.

---
 rtl/ppu_bg_fetch.sv | 158 +++++++++++++++
 tb/tb_ppu_bg_fetch.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_bg_fetch.sv
// PPU background tile fetch sequencer: drives the CHR/CIRAM read port through
// nametable, attribute and two pattern fetches per tile, and steps coarse X
// across a scanline.
module ppu_bg_fetch #(
   parameter int unsigned TILES_PER_LINE = 34
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        dot_en_in,
   input  logic        line_start_in,
   input  logic [14:0] v_in,
   input  logic        bg_pt_sel_in,
   output logic [13:0] chr_a_out,
   output logic        chr_r_nw_out,
   input  logic [7:0]  chr_d_in,
   output logic        busy_out,
   output logic        tile_valid_out,
   output logic [7:0]  tile_nt_out,
   output logic [1:0]  tile_at_out,
   output logic [7:0]  tile_lo_out,
   output logic [7:0]  tile_hi_out,
   output logic        line_done_out
);

   localparam int unsigned V_W   = 15;
   localparam int unsigned A_W   = 14;
   localparam int unsigned D_W   = 8;
   localparam int unsigned CNT_W = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;
   localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(TILES_PER_LINE - 1);

   typedef enum logic [3:0] {
      IDLE, NT0, NT1, AT0, AT1, LO0, LO1, HI0, HI1
   } state_t;

   state_t           state_q, state_d;
   logic [V_W-1:0]   v_q;
   logic [CNT_W-1:0] tile_cnt_q;
   logic [D_W-1:0]   nt_byte_q;
   logic [D_W-1:0]   at_byte_q;
   logic [D_W-1:0]   lo_byte_q;

   logic             addr_en;
   logic [A_W-1:0]   addr_sel;
   logic             cap_nt, cap_at, cap_lo;
   logic             tile_fire;
   logic             last_tile;

   logic [A_W-1:0]   nt_addr, at_addr, lo_addr, hi_addr;
   logic [2:0]       at_shift;
   logic [1:0]       at_sel;
   logic [V_W-1:0]   v_next;

   // Fetch addresses and attribute quadrant select from the internal v copy
   always_comb begin
      nt_addr  = {2'b10, v_q[11:0]};
      at_addr  = {2'b10, v_q[11:10], 4'b1111, v_q[9:7], v_q[4:2]};
      lo_addr  = {1'b0, bg_pt_sel_in, nt_byte_q, 1'b0, v_q[14:12]};
      hi_addr  = lo_addr | 14'h0008;
      at_shift = {v_q[6], v_q[1], 1'b0};
      at_sel   = 2'(at_byte_q >> at_shift);
   end

   // Coarse X increment; wrapping 31 -> 0 flips the horizontal nametable bit
   always_comb begin
      v_next = v_q;
      if (v_q[4:0] == 5'd31) begin
         v_next[4:0] = 5'd0;
         v_next[10]  = ~v_q[10];
      end else begin
         v_next[4:0] = v_q[4:0] + 5'd1;
      end
   end

   // State register
   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and datapath strobes; line_start overrides any dot advance
   always_comb begin
      state_d   = state_q;
      addr_en   = 1'b0;
      addr_sel  = '0;
      cap_nt    = 1'b0;
      cap_at    = 1'b0;
      cap_lo    = 1'b0;
      tile_fire = 1'b0;
      last_tile = 1'b0;
      if (line_start_in) begin
         state_d = NT0;
      end else if (dot_en_in) begin
         unique case (state_q)
            NT0: begin addr_en = 1'b1; addr_sel = nt_addr; state_d = NT1; end
            NT1: begin cap_nt = 1'b1; state_d = AT0; end
            AT0: begin addr_en = 1'b1; addr_sel = at_addr; state_d = AT1; end
            AT1: begin cap_at = 1'b1; state_d = LO0; end
            LO0: begin addr_en = 1'b1; addr_sel = lo_addr; state_d = LO1; end
            LO1: begin cap_lo = 1'b1; state_d = HI0; end
            HI0: begin addr_en = 1'b1; addr_sel = hi_addr; state_d = HI1; end
            HI1: begin
               tile_fire = 1'b1;
               if (tile_cnt_q == LAST_TILE) begin
                  last_tile = 1'b1;
                  state_d   = IDLE;
               end else begin
                  state_d   = NT0;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Address, capture, tile output and line bookkeeping registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v_q            <= '0;
         tile_cnt_q     <= '0;
         nt_byte_q      <= '0;
         at_byte_q      <= '0;
         lo_byte_q      <= '0;
         chr_a_out      <= '0;
         chr_r_nw_out   <= 1'b1;
         busy_out       <= 1'b0;
         tile_valid_out <= 1'b0;
         line_done_out  <= 1'b0;
         tile_nt_out    <= '0;
         tile_at_out    <= '0;
         tile_lo_out    <= '0;
         tile_hi_out    <= '0;
      end else begin
         chr_r_nw_out   <= 1'b1;
         tile_valid_out <= tile_fire;
         line_done_out  <= last_tile;
         if (line_start_in) begin
            v_q        <= v_in;
            tile_cnt_q <= '0;
            busy_out   <= 1'b1;
         end else if (tile_fire) begin
            v_q <= v_next;
            if (last_tile) busy_out   <= 1'b0;
            else           tile_cnt_q <= tile_cnt_q + CNT_W'(1);
         end
         if (addr_en) chr_a_out <= addr_sel;
         if (cap_nt)  nt_byte_q <= chr_d_in;
         if (cap_at)  at_byte_q <= chr_d_in;
         if (cap_lo)  lo_byte_q <= chr_d_in;
         if (tile_fire) begin
            tile_nt_out <= nt_byte_q;
            tile_at_out <= at_sel;
            tile_lo_out <= lo_byte_q;
            tile_hi_out <= chr_d_in;
         end
      end
   end

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// Scoreboard bench for ppu_bg_fetch with a synchronous CHR ROM model.
module tb_ppu_bg_fetch;

   localparam int unsigned TILES = 34;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        dot_en_in;
   logic        line_start_in;
   logic [14:0] v_in;
   logic        bg_pt_sel_in;
   logic [13:0] chr_a_out;
   logic        chr_r_nw_out;
   logic [7:0]  chr_d_in;
   logic        busy_out;
   logic        tile_valid_out;
   logic [7:0]  tile_nt_out;
   logic [1:0]  tile_at_out;
   logic [7:0]  tile_lo_out;
   logic [7:0]  tile_hi_out;
   logic        line_done_out;

   ppu_bg_fetch #(.TILES_PER_LINE(TILES)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .dot_en_in(dot_en_in),
      .line_start_in(line_start_in), .v_in(v_in), .bg_pt_sel_in(bg_pt_sel_in),
      .chr_a_out(chr_a_out), .chr_r_nw_out(chr_r_nw_out), .chr_d_in(chr_d_in),
      .busy_out(busy_out), .tile_valid_out(tile_valid_out),
      .tile_nt_out(tile_nt_out), .tile_at_out(tile_at_out),
      .tile_lo_out(tile_lo_out), .tile_hi_out(tile_hi_out),
      .line_done_out(line_done_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] nt;
      logic [1:0] at;
      logic [7:0] lo;
      logic [7:0] hi;
   } tile_t;

   int checks = 0;
   int errors = 0;

   tile_t       tile_q[$];
   logic [13:0] addr_q[$];
   logic [13:0] obs_a[$];

   logic [7:0]  nt_base   = 8'h41;
   logic [7:0]  at_byte_m = 8'h00;
   int          dot_period = 2;
   int          dot_phase  = 0;
   int          tile_cnt = 0;
   int          done_cnt = 0;
   int          dots_since_start = 0;
   logic [7:0]  first_nt = '0;
   logic [1:0]  first_at = '0;
   logic        mon_en = 1'b0;
   logic [13:0] prev_a = '0;

   // CHR/CIRAM content: attribute area, nametable area, pattern area
   function automatic logic [7:0] rom(input logic [13:0] a);
      if (a[13] === 1'b1) begin
         if (a[9:6] == 4'hF) return at_byte_m;
         return nt_base + 8'(a[4:0]);
      end
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
   endfunction

   // Synchronous ROM: data one clock after address
   always @(posedge clk_in) chr_d_in <= rom(chr_a_out);

   // Dot enable generator, one pulse every dot_period clocks
   always @(negedge clk_in) begin
      dot_phase = (dot_phase + 1) % dot_period;
      dot_en_in = (dot_phase == 0);
   end

   // Dots consumed since the last line_start
   always @(posedge clk_in) begin
      if (line_start_in) dots_since_start <= 0;
      else if (dot_en_in) dots_since_start <= dots_since_start + 1;
   end

   // Output monitor: address stream, tile scoreboard, line_done alignment
   always @(negedge clk_in) begin
      if (mon_en) begin
         if (chr_a_out !== prev_a) begin
            obs_a.push_back(chr_a_out);
            checks++;
            if (addr_q.size() == 0) begin
               errors++;
               $display("FAIL chr_a unexpected: got %h, none expected", chr_a_out);
            end else begin
               logic [13:0] ea;
               ea = addr_q.pop_front();
               if (chr_a_out !== ea) begin
                  errors++;
                  $display("FAIL chr_a: got %h expected %h", chr_a_out, ea);
               end
            end
            prev_a = chr_a_out;
         end
         if (tile_valid_out === 1'b1) begin
            checks++;
            if (tile_q.size() == 0) begin
               errors++;
               $display("FAIL tile_valid unexpected: nt %h", tile_nt_out);
            end else begin
               tile_t et;
               et = tile_q.pop_front();
               if ({tile_nt_out, tile_at_out, tile_lo_out, tile_hi_out} !==
                   {et.nt, et.at, et.lo, et.hi}) begin
                  errors++;
                  $display("FAIL tile %0d: got nt %h at %b lo %h hi %h expected nt %h at %b lo %h hi %h",
                           tile_cnt, tile_nt_out, tile_at_out, tile_lo_out, tile_hi_out,
                           et.nt, et.at, et.lo, et.hi);
               end
            end
            if (tile_cnt == 0) begin
               first_nt = tile_nt_out;
               first_at = tile_at_out;
               checks++;
               if (dots_since_start != 8) begin
                  errors++;
                  $display("FAIL first tile latency: got %0d dots expected 8", dots_since_start);
               end
            end
            tile_cnt++;
         end
         if (line_done_out === 1'b1) begin
            done_cnt++;
            checks++;
            if (tile_valid_out !== 1'b1 || tile_cnt != TILES) begin
               errors++;
               $display("FAIL line_done align: tile_valid %b tiles %0d expected 1 and %0d",
                        tile_valid_out, tile_cnt, TILES);
            end
         end
      end
   end

   // Push the expected address stream and tiles for a full line, then pulse line_start
   task automatic start_line(input logic [14:0] v, input logic pt, input bit flush);
      logic [14:0] vv;
      logic [13:0] na, aa, la, ha;
      logic [7:0]  ab;
      tile_t       t;
      @(negedge clk_in);
      if (flush) begin
         tile_q.delete();
         addr_q.delete();
      end
      vv = v;
      for (int i = 0; i < int'(TILES); i++) begin
         na = {2'b10, vv[11:0]};
         aa = {2'b10, vv[11:10], 4'hF, vv[9:7], vv[4:2]};
         t.nt = rom(na);
         ab = rom(aa);
         case ({vv[6], vv[1]})
            2'b00:   t.at = ab[1:0];
            2'b01:   t.at = ab[3:2];
            2'b10:   t.at = ab[5:4];
            default: t.at = ab[7:6];
         endcase
         la = {1'b0, pt, t.nt, 1'b0, vv[14:12]};
         ha = la | 14'h0008;
         t.lo = rom(la);
         t.hi = rom(ha);
         addr_q.push_back(na);
         addr_q.push_back(aa);
         addr_q.push_back(la);
         addr_q.push_back(ha);
         tile_q.push_back(t);
         if (vv[4:0] == 5'd31) begin
            vv[4:0] = 5'd0;
            vv[10]  = ~vv[10];
         end else begin
            vv[4:0] = vv[4:0] + 5'd1;
         end
      end
      tile_cnt = 0;
      done_cnt = 0;
      obs_a.delete();
      v_in = v;
      bg_pt_sel_in = pt;
      line_start_in = 1'b1;
      @(negedge clk_in);
      line_start_in = 1'b0;
   endtask

   // Wait for line_done within a bound, then check the line's totals
   task automatic wait_done(input string name);
      int n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(negedge clk_in);
         n++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL %s timeout: no line_done after %0d clk", name, n);
      end
      repeat (3) @(negedge clk_in);
      checks++;
      if (tile_cnt != TILES || done_cnt != 1 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL %s line end: tiles %0d done %0d busy %b expected %0d 1 0",
                  name, tile_cnt, done_cnt, busy_out, TILES);
      end
      checks++;
      if (tile_q.size() != 0 || addr_q.size() != 0) begin
         errors++;
         $display("FAIL %s leftovers: tiles %0d addrs %0d expected 0 0",
                  name, tile_q.size(), addr_q.size());
      end
   endtask

   task automatic test_reset();
      dot_period = 2;
      rst_in = 1'b1;
      line_start_in = 1'b1;
      v_in = 15'h1234;
      bg_pt_sel_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_in);
         checks++;
         if ({chr_a_out, chr_r_nw_out, busy_out, tile_valid_out, line_done_out,
              tile_nt_out, tile_at_out, tile_lo_out, tile_hi_out} !== {14'h0, 1'b1, 3'b000, 26'h0}) begin
            errors++;
            $display("FAIL reset cyc %0d: a %h rnw %b busy %b tv %b ld %b nt %h at %b lo %h hi %h expected zeros rnw 1",
                     c, chr_a_out, chr_r_nw_out, busy_out, tile_valid_out, line_done_out,
                     tile_nt_out, tile_at_out, tile_lo_out, tile_hi_out);
         end
      end
      rst_in = 1'b0;
      line_start_in = 1'b0;
      repeat (6) @(negedge clk_in);
      checks++;
      if ({chr_a_out, chr_r_nw_out, busy_out, tile_valid_out, line_done_out} !== {14'h0, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL post-reset idle: a %h rnw %b busy %b tv %b ld %b expected 0 1 0 0 0",
                  chr_a_out, chr_r_nw_out, busy_out, tile_valid_out, line_done_out);
      end
      prev_a = 14'h0;
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      logic [13:0] exp_a[4];
      exp_a[0] = 14'h2000; exp_a[1] = 14'h23C0; exp_a[2] = 14'h0410; exp_a[3] = 14'h0418;
      nt_base = 8'h41;
      at_byte_m = 8'h00;
      dot_period = 4;
      start_line(15'h0000, 1'b0, 1'b0);
      checks++;
      if (busy_out !== 1'b1) begin
         errors++;
         $display("FAIL basic busy: got %b expected 1", busy_out);
      end
      wait_done("basic");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs_a.size() <= i || obs_a[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL basic addr %0d: got %h expected %h", i,
                     (obs_a.size() > i) ? obs_a[i] : 14'h3FFF, exp_a[i]);
         end
      end
      checks++;
      if (first_nt !== 8'h41) begin
         errors++;
         $display("FAIL basic tile_nt: got %h expected 41", first_nt);
      end
   endtask

   task automatic test_pattern_addr();
      nt_base = 8'h41;
      dot_period = 4;
      start_line(15'h5000, 1'b1, 1'b0);
      wait_done("pattern");
      checks++;
      if (obs_a.size() < 4 || obs_a[2] !== 14'h1415 || obs_a[3] !== 14'h141D) begin
         errors++;
         $display("FAIL pattern addrs: got %h %h expected 1415 141D",
                  (obs_a.size() > 2) ? obs_a[2] : 14'h3FFF, (obs_a.size() > 3) ? obs_a[3] : 14'h3FFF);
      end
   endtask

   task automatic test_attribute();
      at_byte_m = 8'hE4;
      dot_period = 3;
      start_line(15'h0002, 1'b0, 1'b0);
      wait_done("attr_a");
      checks++;
      if (obs_a.size() < 2 || obs_a[1] !== 14'h23C0) begin
         errors++;
         $display("FAIL attr addr: got %h expected 23C0", (obs_a.size() > 1) ? obs_a[1] : 14'h3FFF);
      end
      checks++;
      if (first_at !== 2'b01) begin
         errors++;
         $display("FAIL attr v=0002: got %b expected 01", first_at);
      end
      start_line(15'h0042, 1'b0, 1'b0);
      wait_done("attr_b");
      checks++;
      if (first_at !== 2'b11) begin
         errors++;
         $display("FAIL attr v=0042: got %b expected 11", first_at);
      end
   endtask

   task automatic test_coarse_x_wrap();
      at_byte_m = 8'h1B;
      dot_period = 2;
      start_line(15'h001F, 1'b0, 1'b0);
      wait_done("wrap");
      checks++;
      if (obs_a.size() < 5 || obs_a[0] !== 14'h201F || obs_a[4] !== 14'h2400) begin
         errors++;
         $display("FAIL wrap NT addrs: got %h %h expected 201F 2400",
                  (obs_a.size() > 0) ? obs_a[0] : 14'h3FFF, (obs_a.size() > 4) ? obs_a[4] : 14'h3FFF);
      end
   endtask

   task automatic test_restart();
      int n = 0;
      dot_period = 4;
      start_line(15'h0000, 1'b0, 1'b0);
      while (obs_a.size() < 19 && n < 1000) begin
         @(negedge clk_in);
         n++;
      end
      checks++;
      if (obs_a.size() < 19 || tile_cnt != 4 || busy_out !== 1'b1) begin
         errors++;
         $display("FAIL restart setup: addrs %0d tiles %0d busy %b expected 19 4 1",
                  obs_a.size(), tile_cnt, busy_out);
      end
      start_line(15'h0123, 1'b0, 1'b1);
      wait_done("restart");
      checks++;
      if (obs_a.size() < 1 || obs_a[0] !== 14'h2123) begin
         errors++;
         $display("FAIL restart NT addr: got %h expected 2123", (obs_a.size() > 0) ? obs_a[0] : 14'h3FFF);
      end
   endtask

   task automatic test_reset_mid_line();
      int n = 0;
      dot_period = 2;
      start_line(15'h0404, 1'b1, 1'b0);
      while (tile_cnt < 3 && n < 1000) begin
         @(negedge clk_in);
         n++;
      end
      rst_in = 1'b1;
      mon_en = 1'b0;
      @(negedge clk_in);
      checks++;
      if ({chr_a_out, chr_r_nw_out, busy_out, tile_valid_out, line_done_out,
           tile_nt_out, tile_at_out, tile_lo_out, tile_hi_out} !== {14'h0, 1'b1, 3'b000, 26'h0}) begin
         errors++;
         $display("FAIL mid-line reset: a %h rnw %b busy %b tv %b ld %b nt %h expected zeros rnw 1",
                  chr_a_out, chr_r_nw_out, busy_out, tile_valid_out, line_done_out, tile_nt_out);
      end
      rst_in = 1'b0;
      tile_q.delete();
      addr_q.delete();
      prev_a = 14'h0;
      done_cnt = 0;
      mon_en = 1'b1;
      repeat (100) @(negedge clk_in);
      checks++;
      if (done_cnt != 0 || busy_out !== 1'b0 || chr_a_out !== 14'h0) begin
         errors++;
         $display("FAIL after mid-line reset: done %0d busy %b a %h expected 0 0 0",
                  done_cnt, busy_out, chr_a_out);
      end
   endtask

   initial begin
      rst_in = 1'b1;
      line_start_in = 1'b0;
      v_in = '0;
      bg_pt_sel_in = 1'b0;
      dot_en_in = 1'b0;
      test_reset();
      test_basic();
      test_pattern_addr();
      test_attribute();
      test_coarse_x_wrap();
      test_restart();
      test_reset_mid_line();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
